// File: rtl/inventory_mmio_responder.sv
// Inventory MMIO responder: 16 stock counters behind a 32-bit register bus.
// Commands run as a four-state pipeline; register accesses answer one cycle later.
module inventory_mmio_responder #(
    parameter int          N_ITEMS    = 16,
    parameter logic [15:0] THRESH_RST = 16'd10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        low_stock_irq
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FETCH   = 2'd1;
    localparam logic [1:0] S_COMPUTE = 2'd2;
    localparam logic [1:0] S_WB      = 2'd3;

    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_REM = 2'd2;
    localparam logic [1:0] OP_SET = 2'd3;

    logic [1:0]  state;
    logic [15:0] stock [N_ITEMS];
    logic [15:0] thresh;
    logic        last_err;
    logic        irq;
    logic [3:0]  last_item;
    logic [1:0]  op;
    logic [3:0]  item;
    logic [15:0] qty;
    logic [15:0] cur;
    logic [15:0] res;
    logic        res_err;
    logic [15:0] nxt;
    logic        nxt_err;
    logic [16:0] sum;
    logic [15:0] mask;
    logic        busy;
    logic        is_cmd;
    logic        is_stat;
    logic        is_thr;
    logic        is_clr;
    logic        is_stock;
    logic        acc;
    logic        wr_ok;
    logic        rd_err;
    logic [31:0] rd_data;
    logic        unused;

    assign unused   = ^req_addr[1:0];
    assign busy     = (state != S_IDLE);
    assign is_cmd   = (req_addr[7:2] == 6'd0);
    assign is_stat  = (req_addr[7:2] == 6'd1);
    assign is_thr   = (req_addr[7:2] == 6'd2);
    assign is_clr   = (req_addr[7:2] == 6'd3);
    assign is_stock = (req_addr[7:6] == 2'b01);

    // Only a new command collides with one in flight; everything else flows.
    assign req_ready = !(busy && req_valid && req_we && is_cmd);
    assign acc       = req_valid && req_ready;
    assign wr_ok     = acc && req_we && !rd_err;

    always_comb begin
        for (int i = 0; i < N_ITEMS; i++) begin
            mask[i] = (stock[i] < thresh);
        end
    end

    always_comb begin
        rd_err  = 1'b0;
        rd_data = '0;
        unique case (1'b1)
            is_cmd:   rd_err = !req_we;
            is_stat: begin
                rd_err = req_we;
                if (!req_we) begin
                    rd_data = {mask, 8'h00, last_item, 1'b0,
                               irq, last_err, busy};
                end
            end
            is_thr: begin
                if (!req_we) rd_data = {16'h0000, thresh};
            end
            is_clr:   rd_err = !req_we;
            is_stock: begin
                rd_err = req_we;
                if (!req_we) rd_data = {16'h0000, stock[req_addr[5:2]]};
            end
            default:  rd_err = 1'b1;
        endcase
    end

    always_comb begin
        sum     = {1'b0, cur} + {1'b0, qty};
        nxt     = cur;
        nxt_err = 1'b0;
        unique case (op)
            OP_ADD: begin
                nxt     = sum[16] ? 16'hFFFF : sum[15:0];
                nxt_err = sum[16];
            end
            OP_REM: begin
                nxt_err = (qty > cur);
                nxt     = nxt_err ? cur : cur - qty;
            end
            OP_SET:  nxt = qty;
            default: nxt = cur;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= acc;
            resp_rdata <= acc ? rd_data : '0;
            resp_err   <= acc && rd_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            op        <= '0;
            item      <= '0;
            qty       <= '0;
            cur       <= '0;
            res       <= '0;
            res_err   <= 1'b0;
            last_err  <= 1'b0;
            last_item <= '0;
            for (int i = 0; i < N_ITEMS; i++) begin
                stock[i] <= '0;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (wr_ok && is_cmd && req_wdata[1:0] != 2'd0) begin
                        op    <= req_wdata[1:0];
                        item  <= req_wdata[7:4];
                        qty   <= req_wdata[31:16];
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    cur   <= stock[item];
                    state <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    res     <= nxt;
                    res_err <= nxt_err;
                    state   <= S_WB;
                end
                default: begin
                    stock[item] <= res;
                    last_item   <= item;
                    last_err    <= res_err;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thresh <= THRESH_RST;
            irq    <= 1'b0;
        end else begin
            if (wr_ok && is_thr) thresh <= req_wdata[15:0];
            // A low-stock writeback outranks a same-cycle clear.
            if (state == S_WB && res < thresh) begin
                irq <= 1'b1;
            end else if (wr_ok && is_clr && req_wdata[0]) begin
                irq <= 1'b0;
            end
        end
    end

    assign low_stock_irq = irq;

endmodule
